// File: rtl/param_updown_counter.sv
// Parametrised synchronous up/down counter: programmable modulus, parallel load,
// count enable, and wrap-or-saturate behaviour at the ends of the range.
module param_updown_counter #(
    parameter int     WIDTH     = 4,
    parameter longint MODULUS   = 16,
    parameter int     SATURATE  = 0,
    parameter longint RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    // Top of range held in WIDTH+1 bits so MODULUS == 2**WIDTH cannot alias to zero.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_Q   = MAX_EXT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);
    localparam bit               SAT_EN  = (SATURATE != 0);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;

    logic at_max;
    logic at_zero;
    logic at_end;

    assign at_max  = ({1'b0, q_q} == MAX_EXT);
    assign at_zero = (q_q == '0);
    assign at_end  = up ? at_max : at_zero;

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        sat_d  = sat_q;
        if (reset) begin
            q_d   = RST_Q;
            sat_d = 1'b0;
        end else if (load) begin
            q_d   = ({1'b0, load_val} > MAX_EXT) ? MAX_Q : load_val;
            sat_d = 1'b0;
        end else if (en) begin
            if (at_end) begin
                wrap_d = 1'b1;
                if (SAT_EN) begin
                    sat_d = 1'b1;
                end else begin
                    q_d = up ? '0 : MAX_Q;
                end
            end else begin
                q_d   = up ? q_q + 1'b1 : q_q - 1'b1;
                sat_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        q_q    <= q_d;
        wrap_q <= wrap_d;
        sat_q  <= sat_d;
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign sat  = SAT_EN && sat_q;
    assign tc   = !reset && at_end;

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: four parameterisations driven in lockstep,
// checked every cycle against an integer reference model through an expected queue.
module tb_param_updown_counter;

  localparam int N = 4;
  localparam int MOD[N]   = '{16, 10, 10, 8};
  localparam bit SATP[N]  = '{0, 0, 1, 1};
  localparam int RV[N]    = '{0, 0, 0, 5};
  localparam int LMASK[N] = '{15, 15, 15, 7};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] q0, q1, q2;
  logic [2:0] q3;
  logic       tc0, tc1, tc2, tc3;
  logic       wrap0, wrap1, wrap2, wrap3;
  logic       sat0, sat1, sat2, sat3;

  int n_checks = 0;
  int n_fail = 0;

  // One entry per cycle: per instance {tc, sat, wrap, q[3:0]} in 7-bit lanes.
  logic [27:0] exp_q[$];

  int mq[N];
  bit mw[N];
  bit ms[N];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  param_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .RESET_VAL(0)) u_d0 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q0), .tc(tc0), .wrap(wrap0), .sat(sat0));
  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0)) u_d1 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q1), .tc(tc1), .wrap(wrap1), .sat(sat1));
  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .RESET_VAL(0)) u_d2 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q2), .tc(tc2), .wrap(wrap2), .sat(sat2));
  param_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1), .RESET_VAL(5)) u_d3 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val[2:0]),
    .q(q3), .tc(tc3), .wrap(wrap3), .sat(sat3));

  // Driver: applies one cycle of inputs at negedge, advances the model, queues the
  // values every instance must show after the coming posedge.
  task automatic drive(input bit r, input bit e, input bit u, input bit l, input int lv);
    logic [27:0] exp;
    int nxt;
    int v;
    bit t;
    reset    = r;
    en       = e;
    up       = u;
    load     = l;
    load_val = lv[3:0];
    exp      = '0;
    for (int i = 0; i < N; i++) begin
      if (r) begin
        mq[i] = RV[i];
        mw[i] = 1'b0;
        ms[i] = 1'b0;
      end else if (l) begin
        v     = lv & LMASK[i];
        mq[i] = (v < MOD[i]) ? v : MOD[i] - 1;
        mw[i] = 1'b0;
        ms[i] = 1'b0;
      end else if (e) begin
        nxt = u ? mq[i] + 1 : mq[i] - 1;
        if (nxt < 0 || nxt >= MOD[i]) begin
          mw[i] = 1'b1;
          if (SATP[i]) ms[i] = 1'b1;
          else         mq[i] = (nxt < 0) ? MOD[i] - 1 : 0;
        end else begin
          mq[i] = nxt;
          mw[i] = 1'b0;
          ms[i] = 1'b0;
        end
      end else begin
        mw[i] = 1'b0;
      end
      t = !r && (u ? (mq[i] == MOD[i] - 1) : (mq[i] == 0));
      exp[i*7 +: 7] = {t, ms[i], mw[i], 4'(mq[i])};
    end
    exp_q.push_back(exp);
    @(negedge clk);
  endtask

  task automatic step(input bit e, input bit u, input int cycles);
    for (int k = 0; k < cycles; k++) drive(1'b0, e, u, 1'b0, 0);
  endtask

  task automatic do_load(input int lv);
    drive(1'b0, 1'b0, 1'b1, 1'b1, lv);
  endtask

  // Scoreboard monitor: outputs are valid every cycle, so one entry is popped per edge.
  logic [27:0] mon_e;
  logic [27:0] mon_a;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {tc3, sat3, wrap3, 1'b0, q3,
               tc2, sat2, wrap2, q2,
               tc1, sat1, wrap1, q1,
               tc0, sat0, wrap0, q0};
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (mon_a[i*7 +: 4] !== mon_e[i*7 +: 4]) begin
          n_fail++;
          $display("FAIL q[%0d] t=%0t: got %0d, required %0d", i, $time, mon_a[i*7 +: 4], mon_e[i*7 +: 4]);
        end
        n_checks++;
        if (mon_a[i*7+4] !== mon_e[i*7+4]) begin
          n_fail++;
          $display("FAIL wrap[%0d] t=%0t: got %b, required %b", i, $time, mon_a[i*7+4], mon_e[i*7+4]);
        end
        n_checks++;
        if (mon_a[i*7+5] !== mon_e[i*7+5]) begin
          n_fail++;
          $display("FAIL sat[%0d] t=%0t: got %b, required %b", i, $time, mon_a[i*7+5], mon_e[i*7+5]);
        end
        n_checks++;
        if (mon_a[i*7+6] !== mon_e[i*7+6]) begin
          n_fail++;
          $display("FAIL tc[%0d] t=%0t: got %b, required %b", i, $time, mon_a[i*7+6], mon_e[i*7+6]);
        end
      end
    end
  end

  initial begin
    bit ru;
    @(negedge clk);

    // Reset for two cycles, then a long up-count through the wrap.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 20);

    // Load 3 and count down through zero.
    do_load(3);
    step(1'b1, 1'b0, 5);

    // From 7 push up into the top end, then step away.
    do_load(7);
    step(1'b1, 1'b1, 6);
    step(1'b1, 1'b0, 1);

    // Load beats en and clamps; reset beats load.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 12);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 5);

    // Reset in the middle of an up-count.
    do_load(5);
    step(1'b1, 1'b1, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 1);

    // Full-range edge, then hold with en low.
    do_load(15);
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 3);

    // Toggle direction every cycle at the bottom end.
    do_load(0);
    for (int k = 0; k < 6; k++) step(1'b1, k[0], 1);

    // Random traffic with sticky direction so saturation runs occur.
    ru = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) ru = ~ru;
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, ru,
            $urandom_range(0, 11) == 0, int'($urandom_range(0, 15)));
    end

    drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
